// File: rtl/ad9228_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : ad9228_arb_pkg                                                  |
// | Purpose  : Shared defaults, types and helpers for the AD9228 readout       |
// |            arbiter (hold register layout, channel index, output FSM).      |
// | Options  : AD9228_ARB_TIMESTAMP_EN adds a timestamp field to hold_t.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package ad9228_arb_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_CH_W       = $clog2(DEF_NUM_CH);
  localparam int TS_WIDTH       = 32;

  // One-deep per-channel holding register contents.
  typedef struct packed {
`ifdef AD9228_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]       ts;
`endif
    logic [DEF_DATA_WIDTH-1:0] data;
  } hold_t;

  typedef logic [DEF_CH_W-1:0] ch_idx_t;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } out_state_t;

  // Number of channels dropping a sample in one cycle.
  function automatic logic [15:0] drop_total(input logic [DEF_NUM_CH-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < DEF_NUM_CH; i++) begin
      n = n + {15'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad9228_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ad9228_rr_picker                                                |
// | Purpose  : Combinational round-robin picker. Searches req starting at      |
// |            last_grant+1 (wrapping) and returns the first set request.      |
// | Ports    : req         in  NUM_CH  request vector (full and enabled holds) |
// |            last_grant  in  CH_W    index of the most recent load           |
// |            grant_valid out 1       some request is set                     |
// |            grant_idx   out CH_W    winning channel                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ad9228_rr_picker
  import ad9228_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant_idx
);

  logic [2*NUM_CH-1:0] dbl_req;
  logic [2*NUM_CH-1:0] rot_full;
  logic [NUM_CH-1:0]   rot_req;

  // Rotate so that bit k of rot_req is channel (last_grant+1+k) mod NUM_CH.
  assign dbl_req  = {req, req};
  assign rot_full = dbl_req >> (int'(last_grant) + 1);
  assign rot_req  = rot_full[NUM_CH-1:0];

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_valid && rot_req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'((int'(last_grant) + 1 + k) % NUM_CH);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ad9228_readout_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ad9228_readout_arbiter                                          |
// | Purpose  : Latches each AD9228 channel's deserialized sample into a        |
// |            one-deep hold, then serializes the holds round-robin onto a     |
// |            valid/ready stream tagged with the channel index. Counts drops. |
// | Ports    : clk, rstn (async active-low)                                    |
// |            ch_data/ch_valid/ch_enable  per-channel sample, strobe, enable  |
// |            clr_overflow                clears overflow and drop_count      |
// |            m_data/m_ch/m_valid/m_ready output stream                       |
// |            overflow, drop_count        sticky drop flags, saturating count |
// |            m_timestamp                 capture time (timestamp build only) |
// | Options  : AD9228_ARB_TIMESTAMP_EN adds a free-running 32-bit counter and  |
// |            the m_timestamp output.                                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ad9228_readout_arbiter
  import ad9228_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         clr_overflow,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CH_W-1:0]              m_ch,
  output logic                         m_valid,
  input  logic                         m_ready,
`ifdef AD9228_ARB_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]          m_timestamp,
`endif
  output logic [NUM_CH-1:0]            overflow,
  output logic [15:0]                  drop_count
);

  hold_t              hold_q [NUM_CH];
  hold_t              hold_d [NUM_CH];
  logic [NUM_CH-1:0]  hold_full_q, hold_full_d;
  ch_idx_t            last_grant_q, last_grant_d;
  out_state_t         state_q, state_d;
  logic               m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]    m_ch_q, m_ch_d;
  logic [NUM_CH-1:0]  overflow_q, overflow_d;
  logic [15:0]        drop_count_q, drop_count_d;
`ifdef AD9228_ARB_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] m_timestamp_q, m_timestamp_d;
`endif

  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  drop;
  logic               grant_valid;
  ch_idx_t            grant_idx;
  logic               load;
  logic [16:0]        cnt_sum;

  // Disabled holds never compete, so a flushed sample can never be presented.
  assign req = hold_full_q & ch_enable;

  ad9228_rr_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The output register is free when empty or being accepted this cycle.
  assign load = grant_valid && ((state_q == ST_EMPTY) || m_ready);

  always_comb begin
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    last_grant_d = last_grant_q;
    state_d      = state_q;
    m_data_d     = m_data_q;
    m_ch_d       = m_ch_q;
    drop         = '0;
`ifdef AD9228_ARB_TIMESTAMP_EN
    ts_d          = ts_q + 1'b1;
    m_timestamp_d = m_timestamp_q;
`endif

    for (int i = 0; i < NUM_CH; i++) begin
      // A hold being drained this cycle can accept a new sample at once.
      if (ch_valid[i] && ch_enable[i] &&
          (!hold_full_q[i] || (load && grant_idx == ch_idx_t'(i)))) begin
        hold_d[i].data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef AD9228_ARB_TIMESTAMP_EN
        hold_d[i].ts   = ts_q;
`endif
        hold_full_d[i] = 1'b1;
      end else begin
        if (ch_valid[i] && ch_enable[i]) begin
          drop[i] = 1'b1;
        end
        if (!ch_enable[i] || (load && grant_idx == ch_idx_t'(i))) begin
          hold_full_d[i] = 1'b0;
        end
      end
    end

    case (state_q)
      ST_EMPTY:   if (load) state_d = ST_PRESENT;
      ST_PRESENT: if (m_ready && !load) state_d = ST_EMPTY;
      default:    state_d = ST_EMPTY;
    endcase
    m_valid_d = (state_d == ST_PRESENT);

    if (load) begin
      m_data_d     = hold_q[grant_idx].data;
      m_ch_d       = grant_idx;
      last_grant_d = grant_idx;
`ifdef AD9228_ARB_TIMESTAMP_EN
      m_timestamp_d = hold_q[grant_idx].ts;
`endif
    end

    // Clear applies first, so drops in the same cycle survive it.
    overflow_d   = (clr_overflow ? '0 : overflow_q) | drop;
    cnt_sum      = {1'b0, (clr_overflow ? 16'd0 : drop_count_q)} + {1'b0, drop_total(drop)};
    drop_count_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
      hold_full_q   <= '0;
      last_grant_q  <= ch_idx_t'(NUM_CH - 1);
      state_q       <= ST_EMPTY;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_ch_q        <= '0;
      overflow_q    <= '0;
      drop_count_q  <= '0;
`ifdef AD9228_ARB_TIMESTAMP_EN
      ts_q          <= '0;
      m_timestamp_q <= '0;
`endif
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      last_grant_q  <= last_grant_d;
      state_q       <= state_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_ch_q        <= m_ch_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
`ifdef AD9228_ARB_TIMESTAMP_EN
      ts_q          <= ts_d;
      m_timestamp_q <= m_timestamp_d;
`endif
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_ch       = m_ch_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
`ifdef AD9228_ARB_TIMESTAMP_EN
  assign m_timestamp = m_timestamp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ad9228_readout_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ad9228_readout_arbiter                                       |
// | Purpose  : Directed self-checking bench for ad9228_readout_arbiter.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ad9228_readout_arbiter;

  localparam int W = 12;
  localparam int N = 4;

  logic           clk;
  logic           rstn;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_valid;
  logic [N-1:0]   ch_enable;
  logic           clr_overflow;
  logic [W-1:0]   m_data;
  logic [1:0]     m_ch;
  logic           m_valid;
  logic           m_ready;
  logic [N-1:0]   overflow;
  logic [15:0]    drop_count;
`ifdef AD9228_ARB_TIMESTAMP_EN
  logic [31:0]    m_timestamp;
`endif

  int checks = 0;
  int errors = 0;

  ad9228_readout_arbiter dut (
    .clk          (clk),
    .rstn         (rstn),
    .ch_data      (ch_data),
    .ch_valid     (ch_valid),
    .ch_enable    (ch_enable),
    .clr_overflow (clr_overflow),
    .m_data       (m_data),
    .m_ch         (m_ch),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
`ifdef AD9228_ARB_TIMESTAMP_EN
    .m_timestamp  (m_timestamp),
`endif
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    ch_data      = '0;
    ch_valid     = '0;
    ch_enable    = 4'hF;
    clr_overflow = 1'b0;
    m_ready      = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic pulse(input int ch, input logic [W-1:0] d);
    ch_data[ch*W +: W] = d;
    ch_valid           = 4'b0001 << ch;
    tick();
    ch_valid = '0;
  endtask

  initial begin
    // 1: reset state and first-sample latency
    do_reset();
    m_ready = 1'b1;
    tick();
    tick();
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_overflow", {28'd0, overflow}, 32'd0);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
    chk("rst_m_data", {20'd0, m_data}, 32'd0);
    pulse(2, 12'h7FF);
    chk("lat_not_yet", {31'd0, m_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, m_valid}, 32'd1);
    chk("lat_ch", {30'd0, m_ch}, 32'd2);
    chk("lat_data", {20'd0, m_data}, 32'h7FF);
    tick();
    chk("lat_accepted", {31'd0, m_valid}, 32'd0);

    // 2: round-robin order from reset priority
    do_reset();
    m_ready  = 1'b1;
    ch_data  = {12'h333, 12'h222, 12'h111, 12'h000};
    ch_valid = 4'b1111;
    tick();
    ch_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_valid", {31'd0, m_valid}, 32'd1);
      chk("rr_ch", {30'd0, m_ch}, k);
      chk("rr_data", {20'd0, m_data}, 32'h111 * k);
    end
    tick();
    chk("rr_drained", {31'd0, m_valid}, 32'd0);

    // 3: backpressure, hold and drop
    do_reset();
    pulse(1, 12'hAAA);
    tick();
    chk("bp_first", {20'd0, m_data}, 32'hAAA);
    pulse(1, 12'hBBB);
    tick();
    pulse(1, 12'hCCC);
    chk("bp_overflow", {28'd0, overflow}, 32'b0010);
    chk("bp_drop_count", {16'd0, drop_count}, 32'd1);
    repeat (14) tick();
    chk("bp_stable_data", {20'd0, m_data}, 32'hAAA);
    chk("bp_stable_ch", {30'd0, m_ch}, 32'd1);
    chk("bp_stable_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    tick();
    chk("bp_second_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_second_data", {20'd0, m_data}, 32'hBBB);
    tick();
    chk("bp_empty", {31'd0, m_valid}, 32'd0);

    // 4: clear versus drop in the same cycle
    do_reset();
    pulse(3, 12'h123);
    tick();
    pulse(3, 12'h124);
    pulse(3, 12'h125);
    chk("clr_pre_count", {16'd0, drop_count}, 32'd1);
    clr_overflow = 1'b1;
    pulse(3, 12'h126);
    clr_overflow = 1'b0;
    chk("clr_drop_flag", {28'd0, overflow}, 32'b1000);
    chk("clr_drop_count", {16'd0, drop_count}, 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_only_flag", {28'd0, overflow}, 32'd0);
    chk("clr_only_count", {16'd0, drop_count}, 32'd0);

    // 5: disable flushes a held sample without counting a drop
    do_reset();
    pulse(1, 12'h0F1);
    tick();
    pulse(0, 12'h0F0);
    ch_enable = 4'b1110;
    tick();
    pulse(0, 12'h0F2);
    m_ready = 1'b1;
    tick();
    chk("dis_no_ch0", {31'd0, m_valid}, 32'd0);
    ch_enable = 4'hF;
    tick();
    tick();
    chk("dis_flushed", {31'd0, m_valid}, 32'd0);
    chk("dis_drop_count", {16'd0, drop_count}, 32'd0);
    chk("dis_overflow", {28'd0, overflow}, 32'd0);

`ifdef AD9228_ARB_TIMESTAMP_EN
    // 6a: capture on the 100th edge after reset release latches 99
    do_reset();
    m_ready = 1'b1;
    repeat (99) tick();
    pulse(0, 12'h055);
    tick();
    chk("ts_value", m_timestamp, 32'd99);
`endif

    // 6b: asynchronous reset while presenting
    do_reset();
    pulse(2, 12'h5A5);
    tick();
    pulse(2, 12'h5A6);
    pulse(2, 12'h5A7);
    chk("ar_pre_valid", {31'd0, m_valid}, 32'd1);
    chk("ar_pre_count", {16'd0, drop_count}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", {31'd0, m_valid}, 32'd0);
    chk("ar_data", {20'd0, m_data}, 32'd0);
    chk("ar_ch", {30'd0, m_ch}, 32'd0);
    chk("ar_overflow", {28'd0, overflow}, 32'd0);
    chk("ar_count", {16'd0, drop_count}, 32'd0);
`ifdef AD9228_ARB_TIMESTAMP_EN
    chk("ar_ts", m_timestamp, 32'd0);
`endif
    tick();
    rstn    = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();
    chk("ar_holds_gone", {31'd0, m_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
